tag_lookup_pipe: RTL and testbench
==================================

// Module: tag_lookup_pipe
// PURPOSE
//  Registered N-way set-associative tag store with a pipelined lookup port, fill and invalidate ports,
//  and tree-PLRU victim selection. Successor to the combinational per-set hit check: it owns the tag
//  and valid arrays for all sets, reports a priority-encoded hit way plus multi-hit detection, and
//  returns a replacement victim. Sits between the cache controller FSM and the data array.
// PARAMETERS
//  N_WAYS    4   ways per set; power of 2, >=2 (tree-PLRU)
//  N_SETS    16  sets; power of 2, >=2
//  TAG_BITS  22  tag width
//  WAY_BITS  $clog2(N_WAYS)  way index width (derived, do not override)
//  SET_BITS  $clog2(N_SETS)  set index width (derived, do not override)
// PORTS
//  clk             in   1         clock, all state on rising edge
//  rst_n           in   1         asynchronous active-low reset
//  req_valid       in   1         lookup request valid
//  req_ready       out  1         lookup request accepted when valid&ready
//  req_set         in   SET_BITS  set index of lookup
//  req_tag         in   TAG_BITS  tag to compare
//  rsp_valid       out  1         lookup result valid
//  rsp_ready       in   1         consumer takes result when valid&ready
//  rsp_hit         out  1         >=1 valid way matched
//  rsp_miss        out  1         ~rsp_hit while rsp_valid; 0 otherwise
//  rsp_way         out  WAY_BITS  lowest-index matching way; 0 on miss
//  rsp_multi_hit   out  1         >1 valid way matched (error flag)
//  rsp_victim      out  WAY_BITS  replacement way for the looked-up set
//  fill_valid      in   1         write tag into (fill_set, fill_way), set valid
//  fill_set        in   SET_BITS  fill set
//  fill_way        in   WAY_BITS  fill way
//  fill_tag        in   TAG_BITS  fill tag
//  inv_valid       in   1         clear valid bits of all ways in inv_set
//  inv_set         in   SET_BITS  invalidate set
// BEHAVIOUR
//  - Reset (async, rst_n=0): all valid bits 0, all PLRU bits 0, rsp_valid=0, rsp_hit/miss/way/
//    multi_hit/victim=0. Tag contents undefined (don't care, never qualified without valid).
//    Reset mid-operation discards any held response; a request presented during reset is not accepted.
//  - Handshake: req_ready = ~rsp_valid | rsp_ready (single output register, no bubble under
//    back-pressure-free flow). Latency 1: request accepted at edge t -> rsp_valid high after edge t.
//    rsp_valid held and all rsp_* stable while rsp_valid & ~rsp_ready. rsp_valid drops after
//    accept edge unless a new request is accepted at the same edge.
//  - Compare: match[w] = valid[set][w] & (tag[set][w]==req_tag). Hit = |match. rsp_way = lowest w
//    with match[w]=1. rsp_multi_hit = popcount(match)>1.
//  - Lookup uses array state BEFORE the accept edge: a fill/inv at the same edge is not visible
//    to that lookup (no bypass). Controller must not rely on same-cycle visibility.
//  - Victim: lowest-index invalid way in set if any; else tree-PLRU victim of the set. Computed
//    from pre-edge state, registered with the response.
//  - PLRU update: on accepted hit, the set's tree bits are set to point away from rsp_way's path;
//    on fill, point away from fill_way. Miss lookups and invalidates do not touch PLRU.
//    Hit update and fill to the same set at the same edge: fill update applied last (wins).
//  - Fill: tag[fill_set][fill_way]<=fill_tag, valid<=1. Invalidate: valid[inv_set][*]<=0.
//    fill and inv to the same set at the same edge: inv wins (set ends fully invalid, tag written).
//    Different sets: both applied.
//  - Widths: all indices unsigned; no wrap arithmetic. Out-of-range index impossible (power-of-2).
// STRUCTURE
//  - cache_pkg: tree-PLRU helper functions (victim from bits, update-for-way); lookup response
//    struct (hit, way, multi_hit, victim).
//  - Sub-module plru_tree: per-set PLRU bit storage (N_SETS x (N_WAYS-1)), update port for hit
//    and fill with fill priority, combinational victim read by set. Top holds tag/valid arrays,
//    compare, priority encoder and output register.
// TESTING (N_WAYS=4, N_SETS=16, TAG_BITS=22)
//  1 Reset, lookup set 3 tag 0x1234 -> rsp_valid next cycle, miss=1, way=0, victim=0, multi_hit=0.
//  2 Fill set 3 ways 0..3 tags 0xA..0xD, lookup set 3 tag 0xC -> hit=1, way=2; next lookup
//    of full set gives victim=0 (PLRU points away from 2 and prior fills), then hit way 0 -> victim!=0.
//  3 Hold rsp_ready=0 two cycles with req_valid=1 -> req_ready=0, rsp_* stable; rsp_ready=1 ->
//    next request accepted same edge, back-to-back responses, none lost or duplicated.
//  4 Fill set 5 ways 1 and 2 with tag 0x77 -> lookup 0x77: hit=1, way=1, multi_hit=1.
//  5 Same edge: fill set 7 way 0 tag 0x9 and inv set 7 -> lookup 0x9 misses, victim=0;
//    same-edge lookup+fill of set 7 tag 0x9 -> miss (no bypass), following lookup hits.
//  6 Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately; all prior fills miss after release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative tag store.
// NWays/NSets/TagBits here fix the widths of the shared types; keep them in step with the top.
package cache_pkg;

  localparam int unsigned NWays    = 4;
  localparam int unsigned NSets    = 16;
  localparam int unsigned TagBits  = 22;
  localparam int unsigned WayBits  = $clog2(NWays);
  localparam int unsigned SetBits  = $clog2(NSets);
  localparam int unsigned PlruBits = NWays - 1;
  localparam int unsigned NodeBits = (PlruBits > 1) ? $clog2(PlruBits) : 1;

  typedef logic [WayBits-1:0]  way_t;
  typedef logic [PlruBits-1:0] plru_t;
  typedef logic [NodeBits-1:0] node_t;

  typedef struct packed {
    logic hit;
    way_t way;
    logic multi_hit;
    way_t victim;
  } lookup_rsp_t;

  // Heap-ordered tree: node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
  // A node bit names the subtree that holds the victim.
  function automatic way_t plru_victim(plru_t bits);
    node_t idx;
    way_t  way;
    logic  b;
    idx = '0;
    way = '0;
    for (int lvl = 0; lvl < int'(WayBits); lvl++) begin
      b   = bits[idx];
      way = way_t'({way, b});
      idx = node_t'({idx, 1'b1}) + node_t'(b);
    end
    return way;
  endfunction

  function automatic plru_t plru_update(plru_t bits, way_t way);
    plru_t nb;
    node_t idx;
    logic  d;
    nb  = bits;
    idx = '0;
    for (int lvl = int'(WayBits) - 1; lvl >= 0; lvl--) begin
      d       = way[lvl];
      nb[idx] = ~d;
      idx     = node_t'({idx, 1'b1}) + node_t'(d);
    end
    return nb;
  endfunction

endpackage

// File: rtl/tag_lookup_pipe_plru_tree.sv
// Per-set tree-PLRU state with hit and fill update ports and a combinational victim read.
module plru_tree
  import cache_pkg::*;
#(
  parameter int unsigned N_SETS   = NSets,
  parameter int unsigned SET_BITS = $clog2(N_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit_en,
  input  logic [SET_BITS-1:0] hit_set,
  input  way_t                hit_way,
  input  logic                fill_en,
  input  logic [SET_BITS-1:0] fill_set,
  input  way_t                fill_way,
  input  logic [SET_BITS-1:0] rd_set,
  output way_t                rd_victim
);

  plru_t plru_q [N_SETS];
  plru_t plru_d [N_SETS];

  // Fill is applied on top of the hit update so it wins on a shared set.
  always_comb begin
    plru_d = plru_q;
    if (hit_en) begin
      plru_d[hit_set] = plru_update(plru_d[hit_set], hit_way);
    end
    if (fill_en) begin
      plru_d[fill_set] = plru_update(plru_d[fill_set], fill_way);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(N_SETS); s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      plru_q <= plru_d;
    end
  end

  assign rd_victim = plru_victim(plru_q[rd_set]);

endmodule

// File: rtl/tag_lookup_pipe.sv
// Registered N-way set-associative tag store: pipelined lookup with hit/multi-hit/victim
// reporting, fill and whole-set invalidate ports.
module tag_lookup_pipe
  import cache_pkg::*;
#(
  parameter int unsigned N_WAYS   = NWays,
  parameter int unsigned N_SETS   = NSets,
  parameter int unsigned TAG_BITS = TagBits,
  parameter int unsigned WAY_BITS = $clog2(N_WAYS),
  parameter int unsigned SET_BITS = $clog2(N_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_hit,
  output logic                rsp_miss,
  output logic [WAY_BITS-1:0] rsp_way,
  output logic                rsp_multi_hit,
  output logic [WAY_BITS-1:0] rsp_victim,
  input  logic                fill_valid,
  input  logic [SET_BITS-1:0] fill_set,
  input  logic [WAY_BITS-1:0] fill_way,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic                inv_valid,
  input  logic [SET_BITS-1:0] inv_set
);

  logic [TAG_BITS-1:0] tag_q   [N_SETS][N_WAYS];
  logic [N_WAYS-1:0]   valid_q [N_SETS];

  logic [N_WAYS-1:0] set_valid;
  logic [N_WAYS-1:0] match;
  way_t              plru_vict;
  lookup_rsp_t       lookup;
  lookup_rsp_t       rsp_q;
  logic              rsp_valid_q;
  logic              accept;

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign set_valid = valid_q[req_set];

  // Compare and victim selection see pre-edge array state; no fill/inv bypass.
  always_comb begin
    lookup = '0;
    match  = '0;
    for (int w = 0; w < int'(N_WAYS); w++) begin
      match[w] = set_valid[w] && (tag_q[req_set][w] == req_tag);
    end
    for (int w = int'(N_WAYS) - 1; w >= 0; w--) begin
      if (match[w]) lookup.way = way_t'(w);
    end
    lookup.hit       = |match;
    lookup.multi_hit = (match & (match - N_WAYS'(1))) != '0;
    lookup.victim    = plru_vict;
    for (int w = int'(N_WAYS) - 1; w >= 0; w--) begin
      if (!set_valid[w]) lookup.victim = way_t'(w);
    end
  end

  plru_tree #(
    .N_SETS   (N_SETS),
    .SET_BITS (SET_BITS)
  ) u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_en    (accept & lookup.hit),
    .hit_set   (req_set),
    .hit_way   (lookup.way),
    .fill_en   (fill_valid),
    .fill_set  (fill_set),
    .fill_way  (fill_way),
    .rd_set    (req_set),
    .rd_victim (plru_vict)
  );

  // Tags need no reset: they are never used without their valid bit.
  always_ff @(posedge clk) begin
    if (fill_valid) begin
      tag_q[fill_set][fill_way] <= fill_tag;
    end
  end

  // Invalidate is written last so it wins over a fill to the same set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(N_SETS); s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      if (fill_valid) valid_q[fill_set][fill_way] <= 1'b1;
      if (inv_valid)  valid_q[inv_set] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (req_ready) begin
      rsp_valid_q <= req_valid;
      if (req_valid) rsp_q <= lookup;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_q.hit;
  assign rsp_miss      = rsp_valid_q & ~rsp_q.hit;
  assign rsp_way       = rsp_q.way;
  assign rsp_multi_hit = rsp_q.multi_hit;
  assign rsp_victim    = rsp_q.victim;

endmodule

// File: tb/tb_tag_lookup_pipe.sv
// Randomized and directed bench for tag_lookup_pipe against a behavioural cache model.
module tb_tag_lookup_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_set, fill_set, inv_set;
  logic [21:0] req_tag, fill_tag;
  logic        rsp_hit, rsp_miss, rsp_multi_hit, fill_valid, inv_valid;
  logic [1:0]  rsp_way, rsp_victim, fill_way;

  int checks = 0;
  int fails  = 0;

  // Model state: tag store contents and per-set tree-PLRU node bits (node 0 = root).
  logic [21:0] m_tag   [16][4];
  bit          m_valid [16][4];
  bit          m_plru  [16][3];
  bit          e_valid, e_hit, e_multi;
  logic [1:0]  e_way, e_victim;

  tag_lookup_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_set       (req_set),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_miss      (rsp_miss),
    .rsp_way       (rsp_way),
    .rsp_multi_hit (rsp_multi_hit),
    .rsp_victim    (rsp_victim),
    .fill_valid    (fill_valid),
    .fill_set      (fill_set),
    .fill_way      (fill_way),
    .fill_tag      (fill_tag),
    .inv_valid     (inv_valid),
    .inv_set       (inv_set)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] got_vec();
    return {rsp_valid, rsp_hit, rsp_miss, rsp_way, rsp_multi_hit, rsp_victim};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {e_valid, e_hit, e_valid & ~e_hit, e_way, e_multi, e_victim};
  endfunction

  // First invalid way, else follow the tree: each bit says which half holds the victim.
  function automatic int model_victim(int s);
    int node = 0;
    int way  = 0;
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    for (int lvl = 0; lvl < 2; lvl++) begin
      way  = way * 2 + int'(m_plru[s][node]);
      node = 2 * node + 1 + int'(m_plru[s][node]);
    end
    return way;
  endfunction

  function automatic void model_touch(int s, int w);
    int node = 0;
    int d;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      d = (w >> lvl) & 1;
      m_plru[s][node] = (d == 0);
      node = 2 * node + 1 + d;
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
      for (int n = 0; n < 3; n++) m_plru[s][n] = 0;
    end
    e_valid = 0; e_hit = 0; e_multi = 0; e_way = 0; e_victim = 0;
  endfunction

  // Advance model by one clock edge using the current inputs, then step the DUT.
  task automatic tick();
    bit acc;
    int s, cnt, hw;
    acc = req_valid && (!e_valid || rsp_ready);
    if (acc) begin
      s = int'(req_set); cnt = 0; hw = -1;
      for (int w = 0; w < 4; w++) begin
        if (m_valid[s][w] && m_tag[s][w] == req_tag) begin
          cnt++;
          if (hw < 0) hw = w;
        end
      end
      e_valid  = 1;
      e_hit    = (cnt > 0);
      e_multi  = (cnt > 1);
      e_way    = (cnt > 0) ? 2'(hw) : 2'd0;
      e_victim = 2'(model_victim(s));
      if (cnt > 0) model_touch(s, hw);
    end else if (rsp_ready) begin
      e_valid = 0;
    end
    if (fill_valid) begin
      m_tag[fill_set][fill_way]   = fill_tag;
      m_valid[fill_set][fill_way] = 1;
      model_touch(int'(fill_set), int'(fill_way));
    end
    if (inv_valid) for (int w = 0; w < 4; w++) m_valid[inv_set][w] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_set = 0; req_tag = 0; rsp_ready = 1;
    fill_valid = 0; fill_set = 0; fill_way = 0; fill_tag = 0;
    inv_valid = 0; inv_set = 0;
  endtask

  task automatic lookup(input int s, input int tag);
    req_valid = 1; req_set = 4'(s); req_tag = 22'(tag);
    tick();
    req_valid = 0;
  endtask

  task automatic fill(input int s, input int w, input int tag);
    fill_valid = 1; fill_set = 4'(s); fill_way = 2'(w); fill_tag = 22'(tag);
    tick();
    fill_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    checks++;
    if (got_vec() !== 8'h00) begin
      fails++; $display("FAIL reset_outputs got=%b want=%b", got_vec(), 8'h00);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
    end
    lookup(3, 'h1234);
    checks++;
    if (got_vec() !== exp_vec() || {rsp_valid, rsp_miss, rsp_way, rsp_victim} !== 6'b110000) begin
      fails++; $display("FAIL first_lookup_miss got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_hit_plru();
    for (int w = 0; w < 4; w++) fill(3, w, 'hA + w);
    lookup(3, 'hC);
    checks++;
    if (got_vec() !== exp_vec() || rsp_hit !== 1'b1 || rsp_way !== 2'd2) begin
      fails++; $display("FAIL hit_way2 got=%b want=%b", got_vec(), exp_vec());
    end
    lookup(3, 'hA);
    checks++;
    if (got_vec() !== exp_vec() || rsp_victim !== 2'd0 || rsp_way !== 2'd0) begin
      fails++; $display("FAIL plru_victim0 got=%b want=%b", got_vec(), exp_vec());
    end
    lookup(3, 'hB);
    checks++;
    if (got_vec() !== exp_vec() || rsp_victim === 2'd0) begin
      fails++; $display("FAIL plru_after_hit0 got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] held;
    lookup(3, 'hD);
    held = got_vec();
    rsp_ready = 0;
    req_valid = 1; req_set = 4'd3; req_tag = 22'hB;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        fails++; $display("FAIL stall_req_ready cyc=%0d got=%b want=0", i, req_ready);
      end
      tick();
      checks++;
      if (got_vec() !== held || got_vec() !== exp_vec()) begin
        fails++; $display("FAIL stall_stable cyc=%0d got=%b want=%b", i, got_vec(), held);
      end
    end
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_tag = 22'('hA + i);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_req_ready i=%0d got=%b want=1", i, req_ready);
      end
      tick();
      checks++;
      if (got_vec() !== exp_vec() || rsp_way !== 2'(i)) begin
        fails++; $display("FAIL b2b_rsp i=%0d got=%b want=%b", i, got_vec(), exp_vec());
      end
    end
    req_valid = 0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_multi_hit();
    fill(5, 1, 'h77);
    fill(5, 2, 'h77);
    lookup(5, 'h77);
    checks++;
    if (got_vec() !== exp_vec() || {rsp_hit, rsp_way, rsp_multi_hit} !== 4'b1011) begin
      fails++; $display("FAIL multi_hit got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_same_edge();
    fill_valid = 1; fill_set = 4'd7; fill_way = 2'd0; fill_tag = 22'h9;
    inv_valid = 1; inv_set = 4'd7;
    tick();
    fill_valid = 0; inv_valid = 0;
    lookup(7, 'h9);
    checks++;
    if (got_vec() !== exp_vec() || rsp_miss !== 1'b1 || rsp_victim !== 2'd0) begin
      fails++; $display("FAIL inv_wins got=%b want=%b", got_vec(), exp_vec());
    end
    fill_valid = 1; fill_set = 4'd7; fill_way = 2'd0; fill_tag = 22'h9;
    lookup(7, 'h9);
    fill_valid = 0;
    checks++;
    if (got_vec() !== exp_vec() || rsp_miss !== 1'b1) begin
      fails++; $display("FAIL no_bypass got=%b want=%b", got_vec(), exp_vec());
    end
    lookup(7, 'h9);
    checks++;
    if (got_vec() !== exp_vec() || rsp_hit !== 1'b1) begin
      fails++; $display("FAIL fill_visible got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midop();
    rsp_ready = 0;
    lookup(5, 'h77);
    #2 rst_n = 0;
    model_clear();
    #1;
    checks++;
    if (got_vec() !== 8'h00) begin
      fails++; $display("FAIL async_reset got=%b want=%b", got_vec(), 8'h00);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rsp_ready = 1;
    lookup(3, 'hA);
    checks++;
    if (got_vec() !== exp_vec() || rsp_miss !== 1'b1) begin
      fails++; $display("FAIL post_reset_3 got=%b want=%b", got_vec(), exp_vec());
    end
    lookup(5, 'h77);
    checks++;
    if (got_vec() !== exp_vec() || rsp_miss !== 1'b1) begin
      fails++; $display("FAIL post_reset_5 got=%b want=%b", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      req_set    = 4'($urandom_range(0, 3));
      req_tag    = 22'('h100 + $urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      fill_valid = ($urandom_range(0, 2) == 0);
      fill_set   = 4'($urandom_range(0, 3));
      fill_way   = 2'($urandom_range(0, 3));
      fill_tag   = 22'('h100 + $urandom_range(0, 3));
      inv_valid  = ($urandom_range(0, 11) == 0);
      inv_set    = 4'($urandom_range(0, 3));
      #1;
      checks++;
      if (req_ready !== (!e_valid || rsp_ready)) begin
        fails++; $display("FAIL rand_req_ready i=%0d got=%b want=%b", i, req_ready,
                          !e_valid || rsp_ready);
      end
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        fails++; $display("FAIL rand_rsp i=%0d got=%b want=%b", i, got_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_fill_hit_plru();
    test_back_to_back();
    test_multi_hit();
    test_same_edge();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
